// File: rtl/traffic_light_sequencer_if.sv
// Signal bundle between the traffic light sequencer and its environment:
// run enable and demand in, phase code, countdown and strobes out.
interface traffic_light_sequencer_if;
  logic       en;
  logic [3:0] req;
  logic [2:0] Q;
  logic [3:0] remaining;
  logic       tick;
  logic       phase_done;

  modport master (
    output en, req,
    input  Q, remaining, tick, phase_done
  );

  modport slave (
    input  en, req,
    output Q, remaining, tick, phase_done
  );
endinterface

// File: rtl/traffic_light_sequencer.sv
// Four-approach traffic light sequencer: prescaled tick, per-phase countdown,
// gap-out on missing demand and round-robin selection of the next green.
module traffic_light_sequencer #(
  parameter int CLK_DIV   = 100_000_000,
  parameter int GREEN_T   = 8,
  parameter int YELLOW_T  = 3,
  parameter int MIN_GREEN = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  traffic_light_sequencer_if.slave  tl
);

  typedef enum logic {
    GREEN  = 1'b0,
    YELLOW = 1'b1
  } phase_t;

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX     = PW'(CLK_DIV - 1);
  localparam logic [3:0]    GREEN_LOAD  = 4'(GREEN_T);
  localparam logic [3:0]    YELLOW_LOAD = 4'(YELLOW_T);
  localparam logic [3:0]    GAP_LIMIT   = 4'(GREEN_T - MIN_GREEN);

  phase_t        phase, phase_next;
  logic [1:0]    dir, dir_next;
  logic [3:0]    remaining_q, remaining_next;
  logic [PW-1:0] prescaler, prescaler_next;
  logic          phase_done_q, phase_done_next;

  logic          tick_now;
  logic [3:0]    dir_onehot;
  logic          other_demand;
  logic          gap_out;
  logic          max_out;
  logic [1:0]    dir_scan;
  logic [1:0]    cand;

  assign tick_now     = tl.en && (prescaler == PRE_MAX);
  assign dir_onehot   = 4'b0001 << dir;
  assign other_demand = |(tl.req & ~dir_onehot);
  assign max_out      = (remaining_q == 4'd1);
  assign gap_out      = ((remaining_q - 4'd1) <= GAP_LIMIT) && !tl.req[dir] && other_demand;

  // Descending scan so the nearest requesting approach (d+1 first) wins.
  always_comb begin
    dir_scan = dir + 2'd1;
    cand     = '0;
    for (int k = 3; k >= 1; k--) begin
      cand = dir + 2'(k);
      if (tl.req[cand]) begin
        dir_scan = cand;
      end
    end
  end

  always_comb begin
    phase_next      = phase;
    dir_next        = dir;
    remaining_next  = remaining_q;
    prescaler_next  = prescaler;
    phase_done_next = 1'b0;

    if (tl.en) begin
      if (prescaler == PRE_MAX) begin
        prescaler_next = '0;
      end else begin
        prescaler_next = prescaler + PW'(1);
      end
    end

    if (tick_now) begin
      case (phase)
        GREEN: begin
          if (max_out || gap_out) begin
            phase_next      = YELLOW;
            remaining_next  = YELLOW_LOAD;
            phase_done_next = 1'b1;
          end else begin
            remaining_next  = remaining_q - 4'd1;
          end
        end
        YELLOW: begin
          if (remaining_q == 4'd1) begin
            phase_next      = GREEN;
            dir_next        = dir_scan;
            remaining_next  = GREEN_LOAD;
            phase_done_next = 1'b1;
          end else begin
            remaining_next  = remaining_q - 4'd1;
          end
        end
        default: begin
          phase_next = GREEN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase        <= GREEN;
      dir          <= 2'd0;
      remaining_q  <= GREEN_LOAD;
      prescaler    <= '0;
      phase_done_q <= 1'b0;
    end else begin
      phase        <= phase_next;
      dir          <= dir_next;
      remaining_q  <= remaining_next;
      prescaler    <= prescaler_next;
      phase_done_q <= phase_done_next;
    end
  end

  assign tl.Q          = {dir, phase == YELLOW};
  assign tl.remaining  = remaining_q;
  assign tl.tick       = tick_now;
  assign tl.phase_done = phase_done_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Scoreboard bench for traffic_light_sequencer: directed scenarios plus random
// demand/enable/reset, checked against a tick-counting reference model.
module tb_traffic_light_sequencer;

  localparam int CLK_DIV   = 4;
  localparam int GREEN_T   = 5;
  localparam int YELLOW_T  = 2;
  localparam int MIN_GREEN = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  traffic_light_sequencer_if tl ();

  traffic_light_sequencer #(
    .CLK_DIV  (CLK_DIV),
    .GREEN_T  (GREEN_T),
    .YELLOW_T (YELLOW_T),
    .MIN_GREEN(MIN_GREEN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .tl   (tl)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] q;
    logic [3:0] rem;
    logic       tick;
    logic       pd;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int checks = 0;
  int failures = 0;

  // Reference model: phase as direction + colour, time as ticks elapsed in phase.
  int m_pre;
  int m_dir;
  int m_elapsed;
  bit m_yellow;
  bit m_pd;

  function automatic void modelReset();
    m_pre     = 0;
    m_dir     = 0;
    m_elapsed = 0;
    m_yellow  = 1'b0;
    m_pd      = 1'b0;
  endfunction

  function automatic int phaseLen();
    return m_yellow ? YELLOW_T : GREEN_T;
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [3:0] rq);
    exp_t x;
    int   e1;
    int   nd;
    bit   found;
    bit   others;
    @(posedge clk);
    #1;
    reset  = r;
    tl.en  = e;
    tl.req = rq;

    x.q    = 3'(m_dir * 2 + int'(m_yellow));
    x.rem  = 4'(phaseLen() - m_elapsed);
    x.tick = e && (m_pre == CLK_DIV - 1);
    x.pd   = m_pd;
    sb.push_back(x);

    if (r) begin
      modelReset();
    end else if (!e) begin
      m_pd = 1'b0;
    end else if (m_pre != CLK_DIV - 1) begin
      m_pre++;
      m_pd = 1'b0;
    end else begin
      m_pre = 0;
      m_pd  = 1'b0;
      e1    = m_elapsed + 1;
      if (!m_yellow) begin
        others = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (k != m_dir && rq[k]) others = 1'b1;
        end
        if (e1 == GREEN_T || (e1 >= MIN_GREEN && !rq[m_dir] && others)) begin
          m_yellow  = 1'b1;
          m_elapsed = 0;
          m_pd      = 1'b1;
        end else begin
          m_elapsed = e1;
        end
      end else if (e1 == YELLOW_T) begin
        nd    = (m_dir + 1) % 4;
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
          if (!found && rq[(m_dir + k) % 4]) begin
            nd    = (m_dir + k) % 4;
            found = 1'b1;
          end
        end
        m_dir     = nd;
        m_yellow  = 1'b0;
        m_elapsed = 0;
        m_pd      = 1'b1;
      end else begin
        m_elapsed = e1;
      end
    end
  endtask

  task automatic runScenario(input logic [3:0] rq, input int cycles);
    applyStimulus(1'b1, 1'b1, rq);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(1'b0, 1'b1, rq);
    end
  endtask

  task automatic boundFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got timeout expected condition reached", name);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        got = sb.pop_front();
        checkOutput("Q", {1'b0, tl.Q}, {1'b0, got.q});
        checkOutput("remaining", tl.remaining, got.rem);
        checkOutput("tick", {3'b000, tl.tick}, {3'b000, got.tick});
        checkOutput("phase_done", {3'b000, tl.phase_done}, {3'b000, got.pd});
      end
    end
  end

  initial begin
    logic [3:0] rq;
    logic       e;
    logic       r;
    int         n;

    tl.en  = 1'b0;
    tl.req = 4'b0000;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    modelReset();

    $display("[TB] scenario: full demand rotation");
    runScenario(4'b1111, 120);
    $display("[TB] scenario: gap-out to left");
    runScenario(4'b0010, 60);
    $display("[TB] scenario: skip idle approaches");
    runScenario(4'b1000, 80);
    $display("[TB] scenario: idle rotation");
    runScenario(4'b0000, 120);

    $display("[TB] scenario: freeze with remaining=3");
    applyStimulus(1'b1, 1'b1, 4'b0000);
    n = 0;
    while (!(!m_yellow && (GREEN_T - m_elapsed) == 3) && n < 100) begin
      applyStimulus(1'b0, 1'b1, 4'b0000);
      n++;
    end
    if (n >= 100) boundFail("freeze_setup");
    for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 4'b0000);

    $display("[TB] scenario: reset during 011 on tick");
    applyStimulus(1'b1, 1'b1, 4'b1111);
    n = 0;
    while (!(m_dir == 1 && m_yellow && m_pre == CLK_DIV - 1) && n < 200) begin
      applyStimulus(1'b0, 1'b1, 4'b1111);
      n++;
    end
    if (n >= 200) boundFail("reset_setup");
    applyStimulus(1'b1, 1'b1, 4'b1111);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 4'b1111);

    $display("[TB] scenario: random demand/enable/reset");
    rq = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) rq = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 9) != 0);
      r = ($urandom_range(0, 399) == 0);
      applyStimulus(r, e, rq);
    end

    repeat (2) @(posedge clk);
    if (sb.size() != 0) boundFail("scoreboard_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_light_sequencer.md
# traffic_light_sequencer

Timed, demand-aware sequencer for the four-approach traffic light. It drives the 3-bit phase code `Q` consumed by the seven-segment arrow decoder:
- `Q[2:1]` selects the direction: 0 up, 1 left, 2 right, 3 down.
- `Q[0]` selects green arrow (0) or yellow "Y" (1).

It contains a clock prescaler, a per-phase countdown, gap-out on lack of demand and round-robin skipping of idle approaches. It sits between the board clock/sensor inputs and the display decoder.

## Interface
Parameters:
- `CLK_DIV`, default 100_000_000: clock cycles per tick (1 s at 100 MHz); legal ≥ 2.
- `GREEN_T`, default 8: maximum green duration in ticks; legal 1..15.
- `YELLOW_T`, default 3: yellow duration in ticks; legal 1..15.
- `MIN_GREEN`, default 3: minimum ticks of green before gap-out is allowed; legal 1..GREEN_T.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable; 0 freezes prescaler, timer and `Q`.
- `req`  in  4  vehicle demand per approach: bit0 up, bit1 left, bit2 right, bit3 down; level-sensitive.
- `Q`  out  3  phase code to the display decoder, encoded as {dir[1:0], yellow}.
- `remaining`  out  4  ticks left in the current phase, for countdown display.
- `tick`  out  1  one-cycle strobe marking a prescaler wrap.
- `phase_done`  out  1  one-cycle pulse in the first cycle of each new phase.

## Operation
- **Reset:** `Q`=000, `remaining`=GREEN_T, prescaler=0, `phase_done`=0. `tick`=0 because it is derived from the prescaler and `en`.
- **Prescaler:**
  - Counts 0..CLK_DIV-1 while `en`=1, then wraps to 0. Its width is $clog2(CLK_DIV).
  - `tick` = `en` && (prescaler == CLK_DIV-1). It is combinational from registers.
- **Green phase (Q[0]=0, direction d).** Evaluated only on a tick cycle:
  - Max-out: `remaining`==1 → go to yellow of d.
  - Gap-out: `remaining`-1 ≤ GREEN_T-MIN_GREEN, and `req[d]`=0, and any other `req` bit = 1 → go to yellow of d.
  - Otherwise `remaining` decrements by 1.
- **Yellow phase (Q[0]=1).** On a tick with `remaining`==1, go to green of the next direction:
  - Scan d+1, d+2, d+3 (mod 4) and take the first with its `req` bit set.
  - If none is set, take d+1. An idle intersection therefore rotates in fixed order.
  - `req` is sampled on that tick cycle only.
- **Yellow countdown:** on any other tick, `remaining` decrements by 1.
- **Phase entry:** `remaining` loads GREEN_T for green and YELLOW_T for yellow. `phase_done` registers 1 for exactly that first cycle.
- **Freeze (`en`=0):** all registers hold and `tick`=0. When `en` returns to 1, counting resumes from the held prescaler and `remaining` values.
- **Simultaneous `reset` and `tick`:** reset wins.
- **Direction wrap:** direction 3 + 1 wraps to 0.
- **Q encoding:** `Q` is always a legal code 0..7. A green is always followed by the yellow of the same direction; a yellow is never skipped.

## Timing
- **Edge alignment:** the state transition takes effect at the rising edge that ends a tick cycle. `Q`, `remaining` and `phase_done` update on that edge together.
- **Tick spacing:** the first tick after reset deassertion is in cycle CLK_DIV (1-based); later ticks are CLK_DIV cycles apart.
- **Phase lengths:**
  - Green lasts GREEN_T ticks at max-out.
  - Green lasts a minimum of MIN_GREEN ticks at gap-out.
  - Yellow always lasts YELLOW_T ticks.
- **Demand response:** a `req` change affects gap-out on the next tick and direction choice at the next yellow end. There is no input latency beyond that.
- **Reset mid-phase:** in the cycle after the reset edge, `Q`=000, `remaining`=GREEN_T and `phase_done`=0, regardless of the prior phase.

## Test plan
All scenarios use CLK_DIV=4, GREEN_T=5, YELLOW_T=2, MIN_GREEN=2.
1. Reset, `en`=1, `req`=1111 → `Q` cycles 000,001,010,011,100,101,110,111,000. Greens last 20 cycles and yellows 8. The first change (000→001) occurs at cycle 20; `phase_done` pulses once per change.
2. Reset, `req`=0010 → gap-out after 2 ticks: `Q`=001 at cycle 8, then `Q`=010 at cycle 16. Left then holds green for the full 5 ticks while only `req[1]` is set.
3. Reset, `req`=1000 → 000 (2 ticks) → 001 (2 ticks) → 110, skipping left and right. Then 111 → 000 by rotation, since no other request is pending.
4. Reset, `req`=0000 → no gap-out; every green lasts the full 5 ticks, in order up, left, right, down, up.
5. `en`=0 for 50 cycles in green with `remaining`=3 → `Q`, `remaining` and prescaler are unchanged, and `tick`=0 throughout. After `en` returns to 1, the phase ends after exactly 3 more ticks.
6. `reset` asserted during 011 on a tick cycle → next cycle `Q`=000, `remaining`=5, `phase_done`=0, `tick`=0.
